md_issue_ctrl: RTL and testbench
================================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; 0 = in reset.
REQ-003 SHALL have: op_valid  in  1  E-stage instruction valid.
REQ-004 SHALL have: op  in  4  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=msub, 8=mfhi, 9=mflo; 10-15 = none.
REQ-005 SHALL have: rs_val, rt_val  in  32 each  operands.
REQ-006 SHALL have: flush  in  1  kill E-stage instruction (exception/interrupt).
REQ-007 SHALL have: xalu_busy  in  1; xalu_hi, xalu_lo  in  32 each  from the MD unit.
REQ-008 SHALL have: xalu_start  out  1; xalu_op  out  3 (mult=0, multu=1, div=2, divu=3, mthi=4, mtlo=5, msub=6); xalu_a, xalu_b  out  32.
REQ-009 SHALL have: stall  out  1; rd_data  out  32; rd_valid  out  1; wd_err  out  1  sticky watchdog error.

Function
REQ-010 SHALL implement FSM IDLE, ISSUE, WAIT; state, xalu_op, xalu_a, xalu_b and the WAIT counter are registers.
REQ-011 Issue-class ops are op 1-7; read ops are 8-9; all other op values are ignored, no stall.
REQ-012 In IDLE with op_valid=1, flush=0, issue-class op: SHALL latch mapped xalu_op, xalu_a=rs_val, xalu_b=rt_val and go to ISSUE at the next edge; stall=0 that cycle.
REQ-013 xalu_start SHALL be 1 only in ISSUE with flush=0 (one cycle per accepted op); 0 in all other states.
REQ-014 ISSUE SHALL go to WAIT at the next edge when flush=0 and to IDLE when flush=1 (operation cancelled, no start).
REQ-015 WAIT SHALL return to IDLE on the first edge at which xalu_busy=0; flush in WAIT has no effect.
REQ-016 stall SHALL be 1 when op_valid=1, flush=0, op is issue-class or read-class, and state is not IDLE; a stalled op is not accepted.
REQ-017 In IDLE, op_valid=1, flush=0, op=8/9: rd_valid=1 and rd_data=xalu_hi/xalu_lo combinationally, same cycle; otherwise rd_valid=0 and rd_data=0.
REQ-018 flush=1 SHALL force stall=0, rd_valid=0, and block acceptance in that cycle.
REQ-019 A WAIT counter (5 bits) SHALL clear on entry to WAIT and increment each WAIT cycle; if it reaches 16 with xalu_busy=1, wd_err SHALL set and the FSM SHALL go to IDLE.
REQ-020 wd_err SHALL stay 1 until reset; it does not block further issue.
REQ-021 A new issue-class op presented in the cycle WAIT exits (xalu_busy=0) SHALL stall; it is accepted the following cycle in IDLE.

Reset
REQ-022 While reset=0: state=IDLE, xalu_op=0, xalu_a=0, xalu_b=0, counter=0, wd_err=0; xalu_start=0, stall=0, rd_valid=0, rd_data=0.
REQ-023 Reset asserted mid-ISSUE or mid-WAIT SHALL abort immediately to IDLE with no start pulse after deassertion.

Verification
REQ-024 mult, rs=3, rt=-5 in IDLE -> next cycle xalu_start=1, xalu_op=0, xalu_a=3, xalu_b=0xFFFFFFFB; then WAIT until busy drops.
REQ-025 div issued, mflo presented while busy high for 10 cycles -> stall=1 each cycle; after busy falls mflo completes, rd_valid=1, rd_data=xalu_lo.
REQ-026 mthi accepted, flush=1 during ISSUE -> xalu_start stays 0, FSM back in IDLE next edge, stall=0.
REQ-027 Busy held high 20 cycles after issue -> wd_err=1 on the 16th WAIT cycle, FSM IDLE, wd_err stays 1 until reset=0.
REQ-028 reset=0 pulse during WAIT of multu -> all outputs 0 asynchronously; after release, mfhi in IDLE returns xalu_hi with no stall.
REQ-029 op=12 with op_valid=1 in WAIT -> stall=0, rd_valid=0, no state change.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issues mult/div/mthi/mtlo/msub to the MD unit, stalls E-stage while busy, serves mfhi/mflo.
// A 5-bit watchdog in WAIT raises a sticky error and frees the pipeline if the unit hangs.
module md_issue_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [3:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   input  logic        xalu_busy,
   input  logic [31:0] xalu_hi,
   input  logic [31:0] xalu_lo,
   output logic        xalu_start,
   output logic [2:0]  xalu_op,
   output logic [31:0] xalu_a,
   output logic [31:0] xalu_b,
   output logic        stall,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        wd_err
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t      r_state;
   logic [2:0]  r_xalu_op;
   logic [31:0] r_xalu_a;
   logic [31:0] r_xalu_b;
   logic [4:0]  r_cnt;
   logic        r_wd_err;
   logic        w_issue_op;
   logic        w_read_op;
   logic        w_live;
   logic        w_idle;
   logic [4:0]  w_cnt_inc;
   // w_live folds in reset so the combinational outputs are quiet during reset
   assign w_issue_op = (op >= 4'd1) && (op <= 4'd7);
   assign w_read_op  = (op == 4'd8) || (op == 4'd9);
   assign w_live     = op_valid & ~flush & reset;
   assign w_idle     = (r_state == IDLE);
   assign w_cnt_inc  = r_cnt + 5'd1;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_xalu_op <= 3'd0;
         r_xalu_a  <= 32'd0;
         r_xalu_b  <= 32'd0;
         r_cnt     <= 5'd0;
         r_wd_err  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_live && w_issue_op) begin
               r_state   <= ISSUE;
               r_xalu_op <= op[2:0] - 3'd1;
               r_xalu_a  <= rs_val;
               r_xalu_b  <= rt_val;
            end
            ISSUE: begin
               r_state <= flush ? IDLE : WAIT;
               r_cnt   <= 5'd0;
            end
            WAIT: if (!xalu_busy) r_state <= IDLE;
            else begin
               r_cnt <= w_cnt_inc;
               if (w_cnt_inc == 5'd16) begin
                  r_wd_err <= 1'b1;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign xalu_start = (r_state == ISSUE) & ~flush & reset;
   assign xalu_op    = r_xalu_op;
   assign xalu_a     = r_xalu_a;
   assign xalu_b     = r_xalu_b;
   assign wd_err     = r_wd_err;
   assign stall      = w_live & (w_issue_op | w_read_op) & ~w_idle;
   assign rd_valid   = w_live & w_read_op & w_idle;
   assign rd_data    = rd_valid ? (op[0] ? xalu_lo : xalu_hi) : 32'd0;
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed per-feature tasks with hand-computed expectations.
module tb_md_issue_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        flush = 1'b0;
   logic        xalu_busy = 1'b0;
   logic [31:0] xalu_hi = 32'hAAAA5555;
   logic [31:0] xalu_lo = 32'h12345678;
   logic        xalu_start;
   logic [2:0]  xalu_op;
   logic [31:0] xalu_a;
   logic [31:0] xalu_b;
   logic        stall;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        wd_err;
   int          checks = 0;
   int          failures = 0;

   md_issue_ctrl dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .flush(flush), .xalu_busy(xalu_busy), .xalu_hi(xalu_hi), .xalu_lo(xalu_lo),
      .xalu_start(xalu_start), .xalu_op(xalu_op), .xalu_a(xalu_a), .xalu_b(xalu_b),
      .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .wd_err(wd_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic v, input logic [3:0] o);
      op_valid = v;
      op = o;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      present(1'b1, 4'd8);
      step();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
      checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
      checks++; if ({xalu_start, stall, wd_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {xalu_start, stall, wd_err}); end
      checks++; if ({xalu_op, xalu_a, xalu_b} !== 67'd0) begin failures++; $display("FAIL reset_regs got=%h/%h/%h exp=0", xalu_op, xalu_a, xalu_b); end
      present(1'b0, 4'd0);
      reset = 1'b1;
      step();
   endtask

   task automatic test_ignored_ops();
      present(1'b1, 4'd0);
      checks++; if ({stall, rd_valid} !== 2'b00) begin failures++; $display("FAIL ign_op0 got=%b exp=00", {stall, rd_valid}); end
      step();
      present(1'b1, 4'd13);
      step();
      checks++; if (xalu_start !== 1'b0) begin failures++; $display("FAIL ign_start got=%0b exp=0", xalu_start); end
      present(1'b0, 4'd0);
   endtask

   task automatic test_mult();
      rs_val = 32'd3;
      rt_val = 32'hFFFFFFFB;
      present(1'b1, 4'd1);
      checks++; if ({stall, xalu_start} !== 2'b00) begin failures++; $display("FAIL mult_accept got=%b exp=00", {stall, xalu_start}); end
      step();
      present(1'b0, 4'd0);
      checks++; if (xalu_start !== 1'b1) begin failures++; $display("FAIL mult_start got=%0b exp=1", xalu_start); end
      checks++; if ({xalu_op, xalu_a, xalu_b} !== {3'd0, 32'd3, 32'hFFFFFFFB}) begin failures++; $display("FAIL mult_regs got=%0d/%h/%h exp=0/3/fffffffb", xalu_op, xalu_a, xalu_b); end
      xalu_busy = 1'b1;
      step();
      checks++; if (xalu_start !== 1'b0) begin failures++; $display("FAIL mult_wait_start got=%0b exp=0", xalu_start); end
      xalu_busy = 1'b0;
      step();
      present(1'b1, 4'd9);
      checks++; if ({stall, rd_valid} !== 2'b01) begin failures++; $display("FAIL mult_back_idle got=%b exp=01", {stall, rd_valid}); end
      present(1'b0, 4'd0);
   endtask

   task automatic test_div_read();
      rs_val = 32'd100;
      rt_val = 32'd7;
      present(1'b1, 4'd3);
      step();
      present(1'b1, 4'd9);
      checks++; if ({xalu_start, xalu_op} !== {1'b1, 3'd2}) begin failures++; $display("FAIL div_start got=%b exp=1010", {xalu_start, xalu_op}); end
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL div_issue_stall got=%0b exp=1", stall); end
      xalu_busy = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         checks++; if ({stall, rd_valid, rd_data} !== {2'b10, 32'd0}) begin failures++; $display("FAIL div_stall_%0d got=%b/%h exp=10/0", i, {stall, rd_valid}, rd_data); end
         step();
      end
      xalu_busy = 1'b0;
      xalu_lo = 32'h00000E0E;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL div_exit_stall got=%0b exp=1", stall); end
      step();
      checks++; if ({stall, rd_valid, rd_data} !== {2'b01, 32'h00000E0E}) begin failures++; $display("FAIL div_mflo got=%b/%h exp=01/00000e0e", {stall, rd_valid}, rd_data); end
      present(1'b0, 4'd0);
   endtask

   task automatic test_flush();
      rs_val = 32'h55;
      present(1'b1, 4'd5);
      step();
      present(1'b0, 4'd0);
      flush = 1'b1;
      #1;
      checks++; if (xalu_start !== 1'b0) begin failures++; $display("FAIL flush_start got=%0b exp=0", xalu_start); end
      checks++; if (xalu_op !== 3'd4) begin failures++; $display("FAIL flush_op got=%0d exp=4", xalu_op); end
      step();
      flush = 1'b0;
      present(1'b1, 4'd1);
      checks++; if ({xalu_start, stall} !== 2'b00) begin failures++; $display("FAIL flush_idle got=%b exp=00", {xalu_start, stall}); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      present(1'b0, 4'd0);
      checks++; if (xalu_start !== 1'b0) begin failures++; $display("FAIL flush_block got=%0b exp=0", xalu_start); end
   endtask

   task automatic test_watchdog();
      present(1'b1, 4'd2);
      step();
      present(1'b1, 4'd9);
      checks++; if ({xalu_start, xalu_op} !== {1'b1, 3'd1}) begin failures++; $display("FAIL wd_start got=%b exp=1001", {xalu_start, xalu_op}); end
      xalu_busy = 1'b1;
      step();
      for (int i = 1; i <= 15; i++) begin
         checks++; if ({wd_err, stall} !== 2'b01) begin failures++; $display("FAIL wd_cycle_%0d got=%b exp=01", i, {wd_err, stall}); end
         step();
      end
      checks++; if ({wd_err, stall} !== 2'b01) begin failures++; $display("FAIL wd_cycle_16 got=%b exp=01", {wd_err, stall}); end
      step();
      checks++; if ({wd_err, stall, rd_valid} !== 3'b101) begin failures++; $display("FAIL wd_trip got=%b exp=101", {wd_err, stall, rd_valid}); end
      present(1'b1, 4'd6);
      rs_val = 32'h77;
      step();
      present(1'b0, 4'd0);
      checks++; if ({xalu_start, xalu_op, xalu_a} !== {1'b1, 3'd5, 32'h77}) begin failures++; $display("FAIL wd_reissue got=%0b/%0d/%h exp=1/5/77", xalu_start, xalu_op, xalu_a); end
      step();
      present(1'b1, 4'd12);
      checks++; if ({stall, rd_valid, wd_err} !== 3'b001) begin failures++; $display("FAIL wd_op12 got=%b exp=001", {stall, rd_valid, wd_err}); end
      step();
      present(1'b1, 4'd1);
      flush = 1'b1;
      #1;
      checks++; if ({stall, rd_valid} !== 2'b00) begin failures++; $display("FAIL wd_flush_stall got=%b exp=00", {stall, rd_valid}); end
      flush = 1'b0;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL wd_still_wait got=%0b exp=1", stall); end
      present(1'b0, 4'd0);
      xalu_busy = 1'b0;
      step();
      checks++; if (wd_err !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%0b exp=1", wd_err); end
   endtask

   task automatic test_back_to_back();
      present(1'b1, 4'd7);
      step();
      present(1'b0, 4'd0);
      checks++; if ({xalu_start, xalu_op} !== {1'b1, 3'd6}) begin failures++; $display("FAIL b2b_msub got=%b exp=1110", {xalu_start, xalu_op}); end
      xalu_busy = 1'b1;
      step();
      step();
      xalu_busy = 1'b0;
      rs_val = 32'h99;
      present(1'b1, 4'd4);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_exit_stall got=%0b exp=1", stall); end
      step();
      checks++; if ({stall, xalu_start} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {stall, xalu_start}); end
      step();
      present(1'b0, 4'd0);
      checks++; if ({xalu_start, xalu_op, xalu_a} !== {1'b1, 3'd3, 32'h99}) begin failures++; $display("FAIL b2b_divu got=%0b/%0d/%h exp=1/3/99", xalu_start, xalu_op, xalu_a); end
      xalu_busy = 1'b1;
      step();
   endtask

   task automatic test_async_reset();
      xalu_busy = 1'b1;
      present(1'b1, 4'd8);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ar_pre_stall got=%0b exp=1", stall); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if ({xalu_start, stall, rd_valid, wd_err} !== 4'b0000) begin failures++; $display("FAIL ar_flags got=%b exp=0000", {xalu_start, stall, rd_valid, wd_err}); end
      checks++; if ({xalu_op, xalu_a, xalu_b, rd_data} !== 99'd0) begin failures++; $display("FAIL ar_regs got=%0d/%h/%h/%h exp=0", xalu_op, xalu_a, xalu_b, rd_data); end
      step();
      reset = 1'b1;
      xalu_busy = 1'b0;
      xalu_hi = 32'hDEADBEEF;
      #1;
      checks++; if ({stall, rd_valid, rd_data} !== {2'b01, 32'hDEADBEEF}) begin failures++; $display("FAIL ar_mfhi got=%b/%h exp=01/deadbeef", {stall, rd_valid}, rd_data); end
      step();
      checks++; if (xalu_start !== 1'b0) begin failures++; $display("FAIL ar_no_start got=%0b exp=0", xalu_start); end
      present(1'b0, 4'd0);
   endtask

   initial begin
      test_reset();
      test_ignored_ops();
      test_mult();
      test_div_read();
      test_flush();
      test_watchdog();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
